// File: rtl/amplificador_ctrl_if.sv
// Control/status bundle between the push-button front end and the gain controller.
interface amplificador_ctrl_if;
  logic       up;
  logic       down;
  logic       mute;
  logic       A;
  logic       B;
  logic [1:0] level;
  logic [1:0] target;
  logic       busy;

  modport master (
    output up, down, mute,
    input  A, B, level, target, busy
  );

  modport slave (
    input  up, down, mute,
    output A, B, level, target, busy
  );
endinterface

// File: rtl/amplificador_ctrl.sv
// Amplifier gain controller: edge-detected up/down target, mute forces goal 0, A/B/level registered.
// AMP_CTRL_SOFTRAMP_EN: ramp one step per HOLD_CYCLES+1 cycles; undefined: level follows goal one cycle later.
module amplificador_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input logic               clk,
  input logic               rst_n,
  amplificador_ctrl_if.slave bus
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || ((HOLD_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_param
    $error("amplificador_ctrl: HOLD_CYCLES out of range or does not fit CNT_W");
  end

  logic       up_q;
  logic       down_q;
  logic       up_rise;
  logic       down_rise;
  logic [1:0] target_r;
  logic [1:0] level_r;
  logic [1:0] goal;
  logic       busy_w;

  assign up_rise   = bus.up & ~up_q;
  assign down_rise = bus.down & ~down_q;

  // Simultaneous rises cancel; both directions saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      target_r <= 2'd0;
    end else begin
      up_q   <= bus.up;
      down_q <= bus.down;
      if (up_rise && !down_rise && target_r != 2'd3) begin
        target_r <= target_r + 2'd1;
      end else if (down_rise && !up_rise && target_r != 2'd0) begin
        target_r <= target_r - 2'd1;
      end
    end
  end

  always_comb begin
    goal = bus.mute ? 2'd0 : target_r;
  end

`ifdef AMP_CTRL_SOFTRAMP_EN
  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       level_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      level_r <= 2'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      level_r <= level_nxt;
    end
  end

  // Direction is re-evaluated each time IDLE is entered, so a reversed goal
  // turns the ramp around on the very next step.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level_r;
    case (state)
      IDLE: begin
        if (level_r != goal) begin
          level_nxt = (goal > level_r) ? level_r + 2'd1 : level_r - 2'd1;
          cnt_nxt   = HOLD_LOAD;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_w = (state == HOLD) | (level_r != goal);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= 2'd0;
    end else begin
      level_r <= goal;
    end
  end

  assign busy_w = (level_r != goal);
`endif

  assign bus.level  = level_r;
  assign bus.A      = level_r[1];
  assign bus.B      = level_r[0];
  assign bus.target = target_r;
  assign bus.busy   = busy_w;

endmodule

// File: tb/tb_amplificador_ctrl.sv
// Scoreboarded bench for amplificador_ctrl: directed scenarios plus random up/down/mute traffic.
module tb_amplificador_ctrl;
  localparam int H = 4;
`ifdef AMP_CTRL_SOFTRAMP_EN
  localparam int SOFT = 1;
  localparam int STEP_GAP = H + 1;
`else
  localparam int SOFT = 0;
  localparam int STEP_GAP = 2;
`endif

  logic clk;
  logic rst_n;
  amplificador_ctrl_if bus ();

  amplificador_ctrl #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int level;
    int target;
    int busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: gain level, stored target, and edges elapsed since last ramp step.
  int m_level, m_target, m_since, edge_n;
  logic m_upq, m_dnq;
  int prev_level;
  int chg[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level  = 0;
    m_target = 0;
    m_since  = 1000;
    m_upq    = 1'b0;
    m_dnq    = 1'b0;
    prev_level = 0;
  endtask

  task automatic model_edge(input logic u, input logic d, input logic m);
    logic ur, dr;
    int goal;
    ur = u & ~m_upq;
    dr = d & ~m_dnq;
    m_upq = u;
    m_dnq = d;
    goal = m ? 0 : m_target;
    edge_n++;
    if (SOFT != 0) begin
      if (m_since < 1000) m_since++;
      if (m_since > H && m_level != goal) begin
        m_level = (goal > m_level) ? m_level + 1 : m_level - 1;
        m_since = 0;
      end
    end else begin
      m_level = goal;
    end
    if (ur && !dr && m_target < 3) m_target++;
    else if (dr && !ur && m_target > 0) m_target--;
  endtask

  function automatic exp_t expect_now(input logic m);
    exp_t e;
    int goal;
    goal = m ? 0 : m_target;
    e.level  = m_level;
    e.target = m_target;
    e.busy   = ((SOFT != 0 && m_since < H) || m_level != goal) ? 1 : 0;
    return e;
  endfunction

  // One clock: model consumes the inputs seen at this edge, then new inputs are applied.
  task automatic tick(input logic u, input logic d, input logic m);
    @(posedge clk);
    model_edge(bus.up, bus.down, bus.mute);
    #1;
    bus.up   = u;
    bus.down = d;
    bus.mute = m;
    exp_q.push_back(expect_now(m));
  endtask

  task automatic tick_s(input logic u, input logic d, input logic m);
    tick(u, d, m);
    @(negedge clk);
    if (int'(bus.level) != prev_level) begin
      chg.push_back(edge_n);
      prev_level = int'(bus.level);
    end
  endtask

  task automatic settle(input logic m, input int want, input string nm);
    int n;
    n = 0;
    do begin
      tick_s(1'b0, 1'b0, m);
      n++;
    end while (!(int'(bus.level) == want && bus.busy == 1'b0) && n < 60);
    chk(nm, (n < 60) ? 1 : 0, 1);
  endtask

  task automatic check_gaps(input string nm, input int n_exp);
    chk({nm, "_steps"}, chg.size(), n_exp);
    for (int i = 1; i < chg.size(); i++) chk({nm, "_gap"}, chg[i] - chg[i-1], STEP_GAP);
  endtask

  // Monitor: every sampled cycle with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_level",  int'(bus.level),  e.level);
        chk("sb_target", int'(bus.target), e.target);
        chk("sb_busy",   int'(bus.busy),   e.busy);
        chk("sb_ab",     int'({bus.A, bus.B}), e.level);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic u, d, m;
    int n;
    rst_n = 1'b0;
    bus.up = 1'b0;
    bus.down = 1'b0;
    bus.mute = 1'b0;
    edge_n = 0;
    model_reset();

    repeat (5) begin
      @(negedge clk);
      bus.up = 1'($urandom);
      bus.down = 1'($urandom);
      bus.mute = 1'($urandom);
    end
    #1;
    chk("rst_level", int'(bus.level), 0);
    chk("rst_target", int'(bus.target), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ab", int'({bus.A, bus.B}), 0);
    @(negedge clk);
    bus.up = 1'b0;
    bus.down = 1'b0;
    bus.mute = 1'b0;
    rst_n = 1'b1;
    repeat (10) tick_s(1'b0, 1'b0, 1'b0);
    chk("idle_level", int'(bus.level), 0);
    chk("idle_busy", int'(bus.busy), 0);

    // Ramp 0->3 from three quick up pulses, then saturation.
    chg.delete();
    tick_s(1'b1, 1'b0, 1'b0);
    tick_s(1'b0, 1'b0, 1'b0);
    chk("up1_target", int'(bus.target), 1);
    chk("up1_level", int'(bus.level), 0);
    chk("up1_busy", int'(bus.busy), 1);
    tick_s(1'b1, 1'b0, 1'b0);
    chk("step1_level", int'(bus.level), 1);
    chk("step1_busy", int'(bus.busy), SOFT);
    tick_s(1'b0, 1'b0, 1'b0);
    chk("up2_target", int'(bus.target), 2);
    tick_s(1'b1, 1'b0, 1'b0);
    tick_s(1'b0, 1'b0, 1'b0);
    chk("up3_target", int'(bus.target), 3);
    settle(1'b0, 3, "ramp_up_done");
    check_gaps("ramp_up", 3);
    tick_s(1'b1, 1'b0, 1'b0);
    repeat (3) tick_s(1'b0, 1'b0, 1'b0);
    chk("sat_target", int'(bus.target), 3);
    chk("sat_level", int'(bus.level), 3);

    // Mute ramps down; target still editable while muted; unmute returns to target.
    chg.delete();
    tick_s(1'b0, 1'b0, 1'b1);
    settle(1'b1, 0, "mute_done");
    check_gaps("mute", (SOFT != 0) ? 3 : 1);
    tick_s(1'b1, 1'b0, 1'b1);
    tick_s(1'b0, 1'b0, 1'b1);
    chk("mute_up_target", int'(bus.target), 3);
    tick_s(1'b0, 1'b1, 1'b1);
    tick_s(1'b0, 1'b0, 1'b1);
    chk("mute_dn_target", int'(bus.target), 2);
    chk("mute_dn_level", int'(bus.level), 0);
    settle(1'b0, 2, "unmute_done");
    chk("unmute_level", int'(bus.level), 2);

    // Simultaneous rises cancel; down saturates at 0.
    tick_s(1'b1, 1'b1, 1'b0);
    tick_s(1'b0, 1'b0, 1'b0);
    chk("both_target", int'(bus.target), 2);
    repeat (3) begin
      tick_s(1'b0, 1'b1, 1'b0);
      tick_s(1'b0, 1'b0, 1'b0);
    end
    chk("dn_sat_target", int'(bus.target), 0);
    settle(1'b0, 0, "dn_done");

    // Asynchronous reset while the level sits at 2 (mid-hold when ramping).
    repeat (2) begin
      tick_s(1'b1, 1'b0, 1'b0);
      tick_s(1'b0, 1'b0, 1'b0);
    end
    n = 0;
    while (int'(bus.level) != 2 && n < 60) begin
      tick_s(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("pre_rst_level", int'(bus.level), 2);
    if (SOFT != 0) chk("pre_rst_busy", int'(bus.busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_level", int'(bus.level), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_target", int'(bus.target), 0);
    chk("arst_ab", int'({bus.A, bus.B}), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the reference model.
    u = 1'b0;
    d = 1'b0;
    m = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) u = ~u;
      if ($urandom_range(0, 5) == 0) d = ~d;
      if ($urandom_range(0, 29) == 0) m = ~m;
      tick(u, d, m);
    end
    repeat (40) tick(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
